// File: rtl/aes_inv_key_sched_if.sv
// Handshake bundle between the AES-128 inverse key scheduler and its requester/consumer.
// The master side issues requests and accepts round keys; the slave side is the scheduler.
interface aes_inv_key_sched_if;
  logic         start;
  logic         key_last;
  logic [127:0] key_in;
  logic         busy;
  logic [127:0] rk;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic         rk_ready;
  logic         done;

  modport master (
    output start, key_last, key_in, rk_ready,
    input  busy, rk, rk_idx, rk_valid, done
  );

  modport slave (
    input  start, key_last, key_in, rk_ready,
    output busy, rk, rk_idx, rk_valid, done
  );
endinterface

// File: rtl/aes_inv_key_sched.sv
// Iterative AES-128 inverse key scheduler: streams round keys 10 down to 0 from one
// 128-bit register, with a single shared forward/inverse round function.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Entry 0 sits in the top byte, so entry a starts at bit 8*(255-a)+7.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX_TABLE[{~a, 3'b111} -: 8];
endmodule

module aes_inv_key_sched (
  input  logic                  clk,
  input  logic                  rst,
  aes_inv_key_sched_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, FWD, REV} state_e;

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         done_q, done_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] w1p, w2p, w3p;
  logic [31:0] sbox_src, rot_w, sub_w, t_w;
  logic [31:0] w0n, w1n, w2n, w3n;
  logic [127:0] fwd_key, inv_key;

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign {w0, w1, w2, w3} = key_q;
  assign w3p = w3 ^ w2;
  assign w2p = w2 ^ w1;
  assign w1p = w1 ^ w0;

  // One sbox bank serves both directions; only one step runs per cycle.
  assign sbox_src = (state_q == REV) ? w3p : w3;
  assign rot_w    = {sbox_src[23:0], sbox_src[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.a(rot_w[8*b +: 8]), .y(sub_w[8*b +: 8]));
  end

  assign t_w = sub_w ^ {rcon(cnt_q), 24'h0};

  assign w0n     = w0 ^ t_w;
  assign w1n     = w1 ^ w0n;
  assign w2n     = w2 ^ w1n;
  assign w3n     = w3 ^ w2n;
  assign fwd_key = {w0n, w1n, w2n, w3n};
  assign inv_key = {w0 ^ t_w, w1p, w2p, w3p};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          key_d   = bus.key_in;
          cnt_d   = bus.key_last ? 4'd10 : 4'd1;
          state_d = bus.key_last ? REV : FWD;
        end
      end
      FWD: begin
        key_d = fwd_key;
        if (cnt_q == 4'd10) begin
          state_d = REV;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      REV: begin
        if (bus.rk_ready) begin
          if (cnt_q != 4'd0) begin
            key_d = inv_key;
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Outputs come straight from registers, so rk/rk_idx never depend on rk_ready.
  assign bus.busy     = (state_q != IDLE);
  assign bus.rk       = key_q;
  assign bus.rk_idx   = cnt_q;
  assign bus.rk_valid = (state_q == REV);
  assign bus.done     = done_q;
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Self-checking bench for aes_inv_key_sched: FIPS-197 vector table, corner-case sequences
// and random keys checked against a key-expansion model built from GF(2^8) arithmetic.
module tb_aes_inv_key_sched;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_inv_key_sched_if bus();
  aes_inv_key_sched dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [127:0] key_in;
    logic         key_last;
    logic [127:0] model_key;
    logic [127:0] rk10;
    logic [127:0] rk1;
    logic [127:0] rk0;
  } vec_t;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;

  int total = 0;
  int bad   = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [11];
  logic [127:0] got_rk [11];
  logic [3:0]   got_idx [11];
  int           n_hs, first_vld, done_cyc;
  vec_t         vecs [3];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // Sbox from first principles: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
              {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; that cycle is cycle 0 of the request.
  task automatic run_stream(input logic [127:0] key, input logic kl, input logic [127:0] mkey,
                            input bit rnd_ready, input int inj_a, input int inj_b, input string tag);
    logic [127:0] prev_rk;
    logic [3:0]   prev_idx;
    bit           stalled;
    int           lim;
    expand(mkey);
    n_hs = 0; first_vld = -1; done_cyc = -1; stalled = 0;
    prev_rk = '0; prev_idx = '0;
    bus.start = 1'b1; bus.key_last = kl; bus.key_in = key; bus.rk_ready = 1'b0;
    for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      bus.start    = (cyc == inj_a) || (cyc == inj_b);
      bus.key_in   = bus.start ? ~key : key;
      bus.key_last = bus.start ? ~kl : kl;
      if (cyc == 1) chk({tag, " busy@1"}, 128'(bus.busy), 128'(1));
      if (stalled) begin
        chk({tag, " rk stable"}, bus.rk, prev_rk);
        chk({tag, " idx stable"}, 128'(bus.rk_idx), 128'(prev_idx));
      end
      if (bus.done) begin
        done_cyc = cyc;
        chk({tag, " busy@done"}, 128'(bus.busy), 128'(0));
      end
      if (bus.rk_valid && first_vld < 0) first_vld = cyc;
      bus.rk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.rk_valid && bus.rk_ready) begin
        if (n_hs < 11) begin
          got_rk[n_hs]  = bus.rk;
          got_idx[n_hs] = bus.rk_idx;
        end
        n_hs++;
      end
      stalled  = bus.rk_valid && !bus.rk_ready;
      prev_rk  = bus.rk;
      prev_idx = bus.rk_idx;
    end
    chk({tag, " timeout"}, 128'(done_cyc < 0), 128'(0));
    chk({tag, " handshakes"}, 128'(n_hs), 128'(11));
    lim = (n_hs < 11) ? n_hs : 11;
    for (int i = 0; i < lim; i++) begin
      chk($sformatf("%s idx#%0d", tag, i), 128'(got_idx[i]), 128'(10 - i));
      chk($sformatf("%s rk#%0d", tag, i), got_rk[i], exp_rk[10 - i]);
    end
    chk({tag, " first valid cycle"}, 128'(first_vld), 128'(kl ? 1 : 11));
    if (!rnd_ready) chk({tag, " done cycle"}, 128'(done_cyc), 128'(kl ? 12 : 22));
  endtask

  initial begin
    logic [127:0] rkey, in_key;
    logic         rkl;

    vecs[0] = '{FIPS_KEY, 1'b0, FIPS_KEY, FIPS_R10, FIPS_R1, FIPS_KEY};
    vecs[1] = '{FIPS_R10, 1'b1, FIPS_KEY, FIPS_R10, FIPS_R1, FIPS_KEY};
    vecs[2] = '{128'h0, 1'b0, 128'h0, 128'hb4ef5bcb3e92e21123e951cf6f8f188e,
                128'h62636363626363636263636362636363, 128'h0};

    rst = 1'b1;
    bus.start = 1'b0; bus.key_last = 1'b0; bus.key_in = '0; bus.rk_ready = 1'b0;
    build_sbox();
    #12;
    chk("reset rk", bus.rk, 128'h0);
    chk("reset idx", 128'(bus.rk_idx), 128'(0));
    chk("reset valid", 128'(bus.rk_valid), 128'(0));
    chk("reset busy", 128'(bus.busy), 128'(0));
    chk("reset done", 128'(bus.done), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 3; i++) begin
      run_stream(vecs[i].key_in, vecs[i].key_last, vecs[i].model_key, 1'b0, 0, 0,
                 $sformatf("vec%0d", i));
      chk($sformatf("vec%0d rk10", i), got_rk[0], vecs[i].rk10);
      chk($sformatf("vec%0d rk1", i), got_rk[9], vecs[i].rk1);
      chk($sformatf("vec%0d rk0", i), got_rk[10], vecs[i].rk0);
      if (i == 0) chk("vec0 rk9", got_rk[1], FIPS_R9);
      idle(2);
    end

    run_stream(FIPS_KEY, 1'b0, FIPS_KEY, 1'b1, 0, 0, "backpressure");
    idle(2);

    // Junk starts mid-request are ignored; a start in the done cycle is taken.
    run_stream(FIPS_KEY, 1'b0, FIPS_KEY, 1'b0, 5, 15, "start-busy");
    run_stream(FIPS_R10, 1'b1, FIPS_KEY, 1'b0, 0, 0, "start-at-done");
    idle(2);

    bus.start = 1'b1; bus.key_last = 1'b0; bus.key_in = FIPS_KEY; bus.rk_ready = 1'b1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    chk("pre-reset valid", 128'(bus.rk_valid), 128'(1));
    #2 rst = 1'b1;
    #1;
    chk("midrst rk", bus.rk, 128'h0);
    chk("midrst idx", 128'(bus.rk_idx), 128'(0));
    chk("midrst valid", 128'(bus.rk_valid), 128'(0));
    chk("midrst busy", 128'(bus.busy), 128'(0));
    chk("midrst done", 128'(bus.done), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    run_stream(FIPS_KEY, 1'b0, FIPS_KEY, 1'b0, 0, 0, "after-reset");
    idle(2);

    for (int k = 0; k < 6; k++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      rkl  = 1'($urandom_range(0, 1));
      expand(rkey);
      in_key = rkl ? exp_rk[10] : rkey;
      run_stream(in_key, rkl, rkey, 1'b1, 0, 0, $sformatf("rand%0d", k));
      idle(1 + $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aes_inv_key_sched.md
# aes_inv_key_sched

Iterative AES-128 inverse key scheduler. It takes a 128-bit key and streams the eleven round keys in decryption order, round 10 down to round 0, one key per valid/ready handshake. It sits in front of the iterative AES-128 decryption datapath and replaces eleven parallel round-key buses with one 128-bit register and one round-function instance.

## Interface
Parameters:
- none; the block is fixed to AES-128 (Nk=4, Nr=10).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- start  in  1  request pulse; sampled only in IDLE.
- key_last  in  1  qualifies key_in at start:
  - 0: key_in is the cipher key (round 0).
  - 1: key_in is already the round-10 key.
- key_in  in  128  key word w0..w3, w0 in bits 127:96; sampled on the start cycle.
- busy  out  1  high from the cycle after start is accepted until done.
- rk  out  128  current round key.
- rk_idx  out  4  round number of rk (10..0).
- rk_valid  out  1  rk and rk_idx are valid.
- rk_ready  in  1  consumer accepts rk when rk_valid && rk_ready.
- done  out  1  one-cycle pulse after round key 0 is accepted.

## Operation
- **Sbox.** The block uses the team's existing byte sbox module, with 4 instances shared by the forward and inverse steps.
- **Forward step (round i).**
  - t = SubWord(RotWord(w3)) ^ {rcon_i, 24'h0}.
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
- **Inverse step (from round i to round i-1).**
  - w3p = w3^w2, w2p = w2^w1, w1p = w1^w0.
  - w0p = w0 ^ SubWord(RotWord(w3p)) ^ {rcon_i, 24'h0}.
  - Only one step is active per cycle, so the sbox inputs are muxed: w3 in FWD, w3p in REV.
- **Rcon.** rcon_1..rcon_10 = 01,02,04,08,10,20,40,80,1b,36, selected by a 4-bit round counter. Counter values outside 1..10 give rcon 00; this is unreachable in normal operation.
- **States.** IDLE, FWD, REV.
  - **IDLE.**
    - start && key_last=0: key_reg <= key_in, cnt <= 1, go to FWD.
    - start && key_last=1: key_reg <= key_in, cnt <= 10, go to REV.
  - **FWD.**
    - Each cycle: key_reg <= fwd(key_reg, rcon_cnt), cnt <= cnt+1.
    - After the step with cnt=10: cnt <= 10, go to REV.
  - **REV.**
    - rk_valid=1, rk=key_reg, rk_idx=cnt.
    - On handshake with cnt>0: key_reg <= inv(key_reg, rcon_cnt), cnt <= cnt-1.
    - On handshake with cnt=0: go to IDLE and pulse done.
- **start outside IDLE** is ignored. No queueing; key_in and key_last are not sampled.
- **rk while rk_valid=1.** rk and rk_idx hold stable while rk_ready=0; there is no combinational path from rk_ready to rk or rk_idx.
- **rk while rk_valid=0.** rk shows key_reg; it is not guaranteed to be zero.

## Timing
- **Reset values:**
  - state=IDLE, key_reg=0, cnt=0.
  - busy=0, rk=0, rk_idx=0, rk_valid=0, done=0.
- **Reset mid-operation:** the block returns to the reset values asynchronously. No partial key stream resumes after reset.
- **Start cycle numbering:** start is sampled high in IDLE at cycle 0.
- **key_last=0:**
  - busy=1 from cycle 1; FWD occupies cycles 1..10.
  - First rk_valid (idx 10) at cycle 11.
- **key_last=1:** first rk_valid (idx 10) at cycle 1.
- **Stream rate:** with rk_ready held high, one key per cycle.
  - key_last=0: idx 0 at cycle 21, done=1 and busy=0 at cycle 22.
  - key_last=1: idx 0 at cycle 11, done at cycle 12.
- **Back-to-back requests:** start is accepted in the cycle done is high, because state is already IDLE. Minimum start-to-start spacing is 22 cycles (key_last=0) or 12 cycles (key_last=1).
- **Critical path:** sbox + 3 XOR levels (forward w3' chain) or sbox + 2 XOR levels (inverse); one round per cycle.

## Test plan
- **FIPS-197 cipher key, full stream.** key_in=2b7e151628aed2a6abf7158809cf4f3c, key_last=0, rk_ready=1 -> required:
  - cycle 11: rk=d014f9a8c9ee2589e13f0cc8b6630ca6, idx 10.
  - cycle 12: rk=ac7766f319fadc2128d12941575c006e, idx 9.
  - cycle 20: rk=a0fafe1788542cb123a339392a6c7605, idx 1.
  - cycle 21: rk=2b7e1516..., idx 0.
  - cycle 22: done.
- **Round-10 key supplied directly.** key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, key_last=1 -> required: rk_valid at cycle 1 with idx 10; rk=2b7e151628aed2a6abf7158809cf4f3c with idx 0 at cycle 11.
- **All-zero key.** key_in=0, key_last=0 -> required: idx 10 rk=b4ef5bcb3e92e21123e951cf6f8f188e; idx 1 rk=62636363626363636263636362636363; idx 0 rk=0.
- **Backpressure.** rk_ready toggled pseudo-randomly -> required: rk and rk_idx stable while rk_valid && !rk_ready; exactly 11 handshakes with idx 10..0, values as in the FIPS-197 scenario.
- **Start while busy.** start pulsed with a different key_in at cycles 5 and 15 -> required: ignored, stream unchanged. A start in the done cycle is accepted.
- **Reset mid-stream.** rst asserted at cycle 14 (in REV) -> required: all outputs at reset values immediately; after release, a new start produces a correct full stream.
